uart_tx_frame_gen: RTL
======================

Name: uart_tx_frame_gen

Overview:
- Parametrised UART transmit serialiser: successor to the fixed 11-bit parallel-in/serial-out transmitter.
- Builds the frame internally from raw data: start bit, 5..DATA_W data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
- Runs on the baud-rate clock, one bit per cycle, and supports back-to-back frames with no idle gap.
- Sits between the baud generator and the TX pin. Keeps the parallel odd-parity output for frames that carry no parity bit.

Parameters:
- DATA_W, 8: maximum data bits per frame; legal range 5..9.
- LEN_W, 4: width of data_len; must hold DATA_W.

Ports:
- BaudOut  in  1  clock, one rising edge per bit period.
- rst  in  1  asynchronous active-low reset.
- send  in  1  transmit request; sampled on each BaudOut rising edge.
- data_in  in  DATA_W  payload; bit 0 is sent first.
- data_len  in  LEN_W  number of data bits.
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  in  1  0: one stop bit; 1: two stop bits.
- data_out  out  1  serial line; idles high.
- p_parity_out  out  1  odd parity of the captured data when the frame has no parity bit; otherwise 0.
- tx_active  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Single clock BaudOut; reset is asynchronous and active-low. All outputs are registered.
- Reset values, applied immediately on rst low, including mid-frame: data_out=1, tx_active=0, tx_done=0, p_parity_out=0, state=IDLE, bit counter=0. The aborted frame is not resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - data_out=1, tx_active=0.
  - On an edge with send=1, capture data_in, data_len, parity_type and stop_bits into shadow registers and go to START.
  - On that same edge, data_out<=0 and tx_active<=1. Latency from send sampled to start bit on the line is one edge.
- Input changes during a frame are ignored; only the shadow copies are used.
- Length clamp at capture: data_len<5 is used as 5; data_len>DATA_W is used as DATA_W. Data bits above the effective length are masked to 0 for the parity calculation.
- START: 1 cycle, data_out=0. Then DATA.
- DATA:
  - data_out = data[cnt], cnt runs 0..len-1, one cycle per bit.
  - After the last data bit, go to PARITY if parity_type is 01 or 10, else STOP.
- PARITY: 1 cycle. Odd: data_out = ~^data. Even: data_out = ^data.
- STOP: data_out=1 for 1 cycle (stop_bits=0) or 2 cycles (stop_bits=1).
- Frame length in cycles = 1 + len + P + S, where P is 0 or 1 and S is 1 or 2.
- End of frame, at the edge that ends the last stop cycle:
  - tx_done<=1 for exactly one cycle.
  - If send=1: capture again and go straight to START, so data_out<=0 and tx_active stays 1 with no idle cycle.
  - Otherwise go to IDLE with tx_active<=0.
- p_parity_out: updated at capture.
  - parity_type 00/11: p_parity_out = ~^(masked data).
  - parity_type 01/10: p_parity_out = 0.
  - Held until the next capture or reset.
- send held high in IDLE starts a frame; send pulses mid-frame are ignored unless send is high at the end-of-frame edge.
- Counter: LEN_W bits, cleared on entry to DATA and STOP. It does not wrap, because transitions happen at the terminal counts.

Test Plan:
- 8N1, data_in=0x55, send pulsed for 1 cycle:
  - data_out = 0,1,0,1,0,1,0,1,0,1 over 10 cycles, then 1.
  - tx_done high in cycle 11 only; tx_active high for cycles 1-10.
  - p_parity_out=1.
- 7 data bits, odd parity, data_in=0x41:
  - data_out = 0,1,0,0,0,0,0,1,1,1 (10 cycles).
  - p_parity_out=0.
- 8E2, data_in=0xA5:
  - data_out = 0,1,0,1,0,0,1,0,1,0,1,1 (12 cycles).
  - tx_done pulses in cycle 13.
- Back-to-back: send held high with 0x00 then 0xFF, 8N1.
  - Second start bit immediately follows the first frame's stop bit.
  - tx_active never drops; tx_done pulses once per frame.
- Reset mid-frame: rst low during the DATA state of 0x33.
  - Same cycle: data_out=1, tx_active=0, tx_done=0.
  - After release with send=0: the line stays idle.
- Clamp and shadowing: data_len=2 with data_in=0x1F gives 5 data bits 1,1,1,1,1.
  - Changing data_in and parity_type mid-frame does not alter the frame in progress.

Source files
------------

// File: rtl/uart_tx_frame_gen.sv
// UART transmit serialiser: builds start / 5..DATA_W data bits LSB first / optional parity / 1-2 stop
// bits from shadow copies of the request, one bit per BaudOut cycle, with back-to-back frame support.
module uart_tx_frame_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              BaudOut,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    output logic              data_out,
    output logic              p_parity_out,
    output logic              tx_active,
    output logic              tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_has_par;
    logic              r_par_bit;
    logic              r_stop2;

    logic [LEN_W-1:0]  w_len_eff;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_data_m;
    logic              w_data_par;
    logic              w_eof;
    logic              w_capture;

    always_comb begin
        w_len_eff = data_len;
        if (data_len < LEN_W'(5)) begin
            w_len_eff = LEN_W'(5);
        end else if (data_len > LEN_W'(DATA_W)) begin
            w_len_eff = LEN_W'(DATA_W);
        end
    end

    // Bits above the effective length never reach the line and are excluded from parity.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign w_mask[gi] = (LEN_W'(gi) < w_len_eff);
        end
    endgenerate

    assign w_data_m   = data_in & w_mask;
    assign w_data_par = ^w_data_m;
    assign w_eof      = (r_state == STOP) && (!r_stop2 || (r_cnt == LEN_W'(1)));
    assign w_capture  = send && ((r_state == IDLE) || w_eof);

    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_has_par    <= 1'b0;
            r_par_bit    <= 1'b0;
            r_stop2      <= 1'b0;
            data_out     <= 1'b1;
            p_parity_out <= 1'b0;
            tx_active    <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= w_eof;
            if (w_capture) begin
                // Capture from IDLE or straight out of the last stop bit (no idle gap).
                r_shift      <= w_data_m;
                r_len        <= w_len_eff;
                r_has_par    <= ^parity_type;
                r_par_bit    <= parity_type[0] ? ~w_data_par : w_data_par;
                r_stop2      <= stop_bits;
                p_parity_out <= (^parity_type) ? 1'b0 : ~w_data_par;
                r_cnt        <= '0;
                r_state      <= START;
                data_out     <= 1'b0;
                tx_active    <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        data_out  <= 1'b1;
                        tx_active <= 1'b0;
                    end
                    START: begin
                        data_out <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_cnt    <= '0;
                        r_state  <= DATA;
                    end
                    DATA: begin
                        if (r_cnt == r_len - LEN_W'(1)) begin
                            if (r_has_par) begin
                                data_out <= r_par_bit;
                                r_state  <= PARITY;
                            end else begin
                                data_out <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= STOP;
                            end
                        end else begin
                            data_out <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_cnt    <= r_cnt + LEN_W'(1);
                        end
                    end
                    PARITY: begin
                        data_out <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        if (w_eof) begin
                            data_out  <= 1'b1;
                            tx_active <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                    default: begin
                        data_out  <= 1'b1;
                        tx_active <= 1'b0;
                        r_state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
